// File: rtl/bp_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_ctrl_if
//  Description : Bundle of the fetch-side prediction, decode-side resolution,
//                flush and BTB/BHT training signals of bp_update_ctrl.
//                The "slave" modport is the controller; "master" is the
//                fetch/decode/BTB environment around it.
//  Revision    : 1.0  initial release
// ============================================================================
interface bp_update_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  // Prediction records offered by fetch
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic [31:0]      pred_target;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;

  // Resolution of the oldest branch from decode
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_ready;

  // Mispredict restart
  logic             flushbp;
  logic [31:0]      redirect_pc;

  // BTB/BHT training write
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;

  // Status
  logic [OCC_W-1:0] occupancy;
  logic             res_err;

  modport slave (
    input  pred_valid, pred_pc, pred_target, pred_taken, pred_idx,
    output pred_ready,
    input  res_valid, res_taken, res_target,
    output res_ready,
    output flushbp, redirect_pc,
    output upd_valid, upd_idx, upd_pc, upd_target, upd_taken,
    input  upd_ready,
    output occupancy, res_err
  );

  modport master (
    output pred_valid, pred_pc, pred_target, pred_taken, pred_idx,
    input  pred_ready,
    output res_valid, res_taken, res_target,
    input  res_ready,
    input  flushbp, redirect_pc,
    input  upd_valid, upd_idx, upd_pc, upd_target, upd_taken,
    output upd_ready,
    input  occupancy, res_err
  );
endinterface
`default_nettype wire

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_ctrl
//  Description : In-flight branch prediction queue. Fetch pushes prediction
//                records; decode resolves the oldest one. A mispredict
//                flushes the queue and emits a one-cycle restart; every
//                resolved record produces one BTB/BHT training write.
//                Optional macro BP_PERF_CNT_EN adds saturating branch and
//                mispredict counters (br_cnt, mp_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BP_PERF_CNT_EN
  output logic [15:0]       br_cnt,
  output logic [15:0]       mp_cnt,
`endif
  bp_update_ctrl_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Queue storage (data only; validity is tracked by the pointers)
  logic [31:0]      r_q_pc     [DEPTH];
  logic [31:0]      r_q_target [DEPTH];
  logic             r_q_taken  [DEPTH];
  logic [IDX_W-1:0] r_q_idx    [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  state_t           r_state;
  logic             r_flush;
  logic [31:0]      r_redirect;
  logic             r_res_err;
  logic             r_upd_valid;
  logic [IDX_W-1:0] r_upd_idx;
  logic [31:0]      r_upd_pc;
  logic [31:0]      r_upd_target;
  logic             r_upd_taken;

  logic             w_pred_ready;
  logic             w_res_ready;
  logic             w_empty;
  logic             w_acc;
  logic             w_pop;
  logic             w_mp;
  logic             w_flush_now;
  logic             w_enq;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_target;
  logic             w_head_taken;
  logic [IDX_W-1:0] w_head_idx;
  logic [31:0]      w_redirect;

  // Handshake decode. Enqueue sees only the occupancy at the start of the
  // cycle, so a simultaneous pop never frees a slot for the same cycle.
  assign w_pred_ready  = (r_occ < OCC_W'(DEPTH));
  assign w_res_ready   = (r_state == ST_IDLE);
  assign w_empty       = (r_occ == '0);
  assign w_acc         = bus.res_valid && w_res_ready;
  assign w_pop         = w_acc && !w_empty;

  assign w_head_pc     = r_q_pc[r_rd_ptr];
  assign w_head_target = r_q_target[r_rd_ptr];
  assign w_head_taken  = r_q_taken[r_rd_ptr];
  assign w_head_idx    = r_q_idx[r_rd_ptr];

  // A taken branch also mispredicts when it went somewhere other than the
  // predicted target; a not-taken resolution ignores the target.
  assign w_mp          = (w_head_taken != bus.res_taken) ||
                         (bus.res_taken && (w_head_target != bus.res_target));
  assign w_flush_now   = w_pop && w_mp;
  assign w_redirect    = bus.res_taken ? bus.res_target : (w_head_pc + 32'd4);

  // A record arriving in the same cycle as a flush is younger than the
  // mispredicted branch and is on the wrong path, so it is dropped.
  assign w_enq         = bus.pred_valid && w_pred_ready && !w_flush_now;

  assign bus.pred_ready  = w_pred_ready;
  assign bus.res_ready   = w_res_ready;
  assign bus.flushbp     = r_flush;
  assign bus.redirect_pc = r_redirect;
  assign bus.upd_valid   = r_upd_valid;
  assign bus.upd_idx     = r_upd_idx;
  assign bus.upd_pc      = r_upd_pc;
  assign bus.upd_target  = r_upd_target;
  assign bus.upd_taken   = r_upd_taken;
  assign bus.occupancy   = r_occ;
  assign bus.res_err     = r_res_err;

  // Record storage write at the tail slot
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]     <= bus.pred_pc;
      r_q_target[r_wr_ptr] <= bus.pred_target;
      r_q_taken[r_wr_ptr]  <= bus.pred_taken;
      r_q_idx[r_wr_ptr]    <= bus.pred_idx;
    end
  end

  // Update FSM, queue pointers, flush pulse and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_flush      <= 1'b0;
      r_redirect   <= '0;
      r_res_err    <= 1'b0;
      r_upd_valid  <= 1'b0;
      r_upd_idx    <= '0;
      r_upd_pc     <= '0;
      r_upd_target <= '0;
      r_upd_taken  <= 1'b0;
    end else begin
      r_flush <= 1'b0;

      if (w_acc && w_empty) begin
        r_res_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state      <= ST_REQ;
            r_upd_valid  <= 1'b1;
            r_upd_idx    <= w_head_idx;
            r_upd_pc     <= w_head_pc;
            r_upd_target <= bus.res_target;
            r_upd_taken  <= bus.res_taken;
          end
        end
        ST_REQ: begin
          if (bus.upd_ready) begin
            r_state     <= ST_IDLE;
            r_upd_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_upd_valid <= 1'b0;
        end
      endcase

      if (w_flush_now) begin
        // Drop every younger record; restart the ring from slot 0.
        r_flush    <= 1'b1;
        r_redirect <= w_redirect;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_occ      <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        case ({w_enq, w_pop})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [15:0] r_br_cnt;
  logic [15:0] r_mp_cnt;

  // Saturating counts of resolved branches and of mispredicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_pop && (r_br_cnt != 16'hFFFF)) begin
        r_br_cnt <= r_br_cnt + 16'd1;
      end
      if (w_flush_now && (r_mp_cnt != 16'hFFFF)) begin
        r_mp_cnt <= r_mp_cnt + 16'd1;
      end
    end
  end

  assign br_cnt = r_br_cnt;
  assign mp_cnt = r_mp_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_update_ctrl
//  Description : Self-checking bench for bp_update_ctrl (DEPTH=4, IDX_W=5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_update_ctrl;

  localparam int DEPTH = 4;
  localparam int IDX_W = 5;

  logic clk;
  logic reset;

`ifdef BP_PERF_CNT_EN
  logic [15:0] br_cnt;
  logic [15:0] mp_cnt;
`endif

  bp_update_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  bp_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef BP_PERF_CNT_EN
    .br_cnt (br_cnt),
    .mp_cnt (mp_cnt),
`endif
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      tgt;
    logic             tk;
    logic [IDX_W-1:0] idx;
  } rec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      pc;
    logic [31:0]      tgt;
    logic             tk;
  } upd_t;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      tgt;
    logic             tk;
    logic [IDX_W-1:0] idx;
    logic             rtk;
    logic [31:0]      rtg;
    logic             exp_mp;
    logic [31:0]      exp_red;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_hs  = 0;

  // Reference model state
  rec_t        m_q[$];
  upd_t        sb[$];
  logic        m_req      = 1'b0;
  logic        m_flush    = 1'b0;
  logic [31:0] m_redirect = 32'd0;
  logic        m_err      = 1'b0;
  upd_t        e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Training-write scoreboard: compare at every upd handshake
  always @(negedge clk) begin
    if (!reset && bus.upd_valid && bus.upd_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL upd_unexpected: got update pc 0x%0h, expected none", bus.upd_pc);
      end else begin
        e_mon = sb.pop_front();
        chk("upd_idx",    32'(bus.upd_idx), 32'(e_mon.idx));
        chk("upd_pc",     bus.upd_pc,       e_mon.pc);
        chk("upd_target", bus.upd_target,   e_mon.tgt);
        chk("upd_taken",  32'(bus.upd_taken), 32'(e_mon.tk));
      end
    end
  end

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_req      = 1'b0;
    m_flush    = 1'b0;
    m_redirect = 32'd0;
    m_err      = 1'b0;
  endtask

  // One clock: advance the model with the current inputs, then check outputs
  task automatic step();
    logic acc, pop, mp, enq;
    rec_t h;
    upd_t u;
    acc = bus.res_valid && !m_req;
    pop = acc && (m_q.size() != 0);
    enq = bus.pred_valid && (m_q.size() < DEPTH);
    mp  = 1'b0;
    if (acc && m_q.size() == 0) m_err = 1'b1;
    if (m_req && bus.upd_ready) m_req = 1'b0;
    m_flush = 1'b0;
    if (pop) begin
      h = m_q.pop_front();
      mp = (h.tk != bus.res_taken) || (bus.res_taken && (h.tgt != bus.res_target));
      u.idx = h.idx; u.pc = h.pc; u.tgt = bus.res_target; u.tk = bus.res_taken;
      sb.push_back(u);
      m_req = 1'b1;
      if (mp) begin
        m_flush    = 1'b1;
        m_redirect = bus.res_taken ? bus.res_target : (h.pc + 32'd4);
        m_q.delete();
      end
    end
    if (enq && !mp) begin
      h.pc = bus.pred_pc; h.tgt = bus.pred_target; h.tk = bus.pred_taken; h.idx = bus.pred_idx;
      m_q.push_back(h);
    end
    tick();
    chk("flushbp",     32'(bus.flushbp),   32'(m_flush));
    chk("redirect_pc", bus.redirect_pc,    m_redirect);
    chk("occupancy",   32'(bus.occupancy), m_q.size());
    chk("res_err",     32'(bus.res_err),   32'(m_err));
    chk("upd_valid",   32'(bus.upd_valid), 32'(m_req));
    chk("res_ready",   32'(bus.res_ready), 32'(!m_req));
    chk("pred_ready",  32'(bus.pred_ready), 32'(m_q.size() < DEPTH));
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic [IDX_W-1:0] idx);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_target = tgt;
    bus.pred_taken  = tk;
    bus.pred_idx    = idx;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tgt);
    bus.res_valid  = 1'b1;
    bus.res_taken  = tk;
    bus.res_target = tgt;
  endtask

  // Resolve the current head exactly as predicted
  task automatic resolve_correct();
    set_res(m_q[0].tk, m_q[0].tgt);
    step();
    bus.res_valid = 1'b0;
    step();
  endtask

  vec_t vecs[6];
  int   acc_cnt;
  int   hs0;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 1'b1, 5'd3,  1'b1, 32'h0000_0200, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0040, 32'h0000_0080, 1'b1, 5'd4,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044};
    vecs[2] = '{32'h0000_0300, 32'h0000_0400, 1'b0, 5'd9,  1'b1, 32'h0000_0500, 1'b1, 32'h0000_0500};
    vecs[3] = '{32'h0000_0500, 32'h0000_0600, 1'b1, 5'd17, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0700};
    vecs[4] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 5'd31, 1'b0, 32'h0000_0999, 1'b0, 32'h0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 5'd0,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};

    reset           = 1'b1;
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_target = '0;
    bus.pred_taken  = 1'b0;
    bus.pred_idx    = '0;
    bus.res_valid   = 1'b0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
    bus.upd_ready   = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_occupancy",  32'(bus.occupancy),  32'd0);
    chk("rst_flushbp",    32'(bus.flushbp),    32'd0);
    chk("rst_upd_valid",  32'(bus.upd_valid),  32'd0);
    chk("rst_res_err",    32'(bus.res_err),    32'd0);
    chk("rst_redirect",   bus.redirect_pc,     32'd0);
    chk("rst_upd_pc",     bus.upd_pc,          32'd0);
    chk("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("rst_res_ready",  32'(bus.res_ready),  32'd1);
    reset = 1'b0;
    tick();

    // Single-record resolve vectors
    for (int i = 0; i < 6; i++) begin
      set_pred(vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].idx);
      step();
      bus.pred_valid = 1'b0;
      set_res(vecs[i].rtk, vecs[i].rtg);
      step();
      bus.res_valid = 1'b0;
      chk($sformatf("vec%0d_flush", i), 32'(bus.flushbp), 32'(vecs[i].exp_mp));
      if (vecs[i].exp_mp) chk($sformatf("vec%0d_redirect", i), bus.redirect_pc, vecs[i].exp_red);
      chk($sformatf("vec%0d_upd_valid", i), 32'(bus.upd_valid), 32'd1);
      step();
      chk($sformatf("vec%0d_flush_end", i), 32'(bus.flushbp), 32'd0);
    end

    // Fill: five back-to-back offers, four accepted
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      set_pred(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), i[0], IDX_W'(i + 10));
      if (bus.pred_ready) acc_cnt++;
      step();
    end
    bus.pred_valid = 1'b0;
    chk("fill_accepted",   acc_cnt,             32'd4);
    chk("fill_pred_ready", 32'(bus.pred_ready), 32'd0);
    chk("fill_occupancy",  32'(bus.occupancy),  32'd4);
    for (int i = 0; i < 4; i++) resolve_correct();

    // Pointer wrap with simultaneous enqueue and correct pop
    set_pred(32'h3000, 32'h3100, 1'b1, 5'd1); step();
    set_pred(32'h3004, 32'h3104, 1'b0, 5'd2); step();
    set_pred(32'h3008, 32'h3108, 1'b1, 5'd3);
    set_res(m_q[0].tk, m_q[0].tgt);
    step();
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    chk("simul_occupancy", 32'(bus.occupancy), 32'd2);
    step();
    resolve_correct();
    resolve_correct();

    // Mispredict with three queued plus a dropped same-cycle enqueue
    set_pred(32'h40, 32'h80, 1'b1, 5'd5); step();
    set_pred(32'h50, 32'h90, 1'b0, 5'd6); step();
    set_pred(32'h60, 32'hA0, 1'b1, 5'd7); step();
    set_pred(32'h70, 32'hB0, 1'b1, 5'd8);
    set_res(1'b0, 32'h0);
    step();
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    chk("mp3_flush",     32'(bus.flushbp),   32'd1);
    chk("mp3_redirect",  bus.redirect_pc,    32'h44);
    chk("mp3_occupancy", 32'(bus.occupancy), 32'd0);
    step();
    chk("mp3_flush_end", 32'(bus.flushbp),   32'd0);

    // Training-write backpressure
    set_pred(32'h100, 32'h200, 1'b1, 5'd7); step();
    bus.pred_valid = 1'b0;
    bus.upd_ready  = 1'b0;
    hs0 = n_hs;
    set_res(1'b1, 32'h200);
    step();
    set_res(1'b0, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_upd_valid",  32'(bus.upd_valid), 32'd1);
      chk("bp_upd_pc",     bus.upd_pc,         32'h100);
      chk("bp_upd_target", bus.upd_target,     32'h200);
      chk("bp_upd_idx",    32'(bus.upd_idx),   32'd7);
      chk("bp_res_ready",  32'(bus.res_ready), 32'd0);
    end
    bus.res_valid = 1'b0;
    bus.upd_ready = 1'b1;
    step();
    step();
    chk("bp_handshakes", n_hs - hs0, 32'd1);

    // Resolve with an empty queue
    set_res(1'b1, 32'h500);
    step();
    bus.res_valid = 1'b0;
    chk("empty_res_err", 32'(bus.res_err),   32'd1);
    chk("empty_flush",   32'(bus.flushbp),   32'd0);
    chk("empty_upd",     32'(bus.upd_valid), 32'd0);
    step();
    step();
    chk("empty_res_err_sticky", 32'(bus.res_err), 32'd1);

    // Reset while a training write is pending with two records queued
    for (int i = 0; i < 3; i++) begin
      set_pred(32'h800 + 32'(i * 4), 32'h900, 1'b1, IDX_W'(i));
      step();
    end
    bus.pred_valid = 1'b0;
    bus.upd_ready  = 1'b0;
    set_res(1'b1, 32'h900);
    step();
    bus.res_valid = 1'b0;
    chk("pre_rst_occupancy", 32'(bus.occupancy), 32'd2);
    chk("pre_rst_upd_valid", 32'(bus.upd_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_mid_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_mid_res_err",   32'(bus.res_err),   32'd0);
    model_reset();
    bus.upd_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    step();
    chk("post_rst_pred_ready", 32'(bus.pred_ready), 32'd1);

    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
